// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole mole scheduler.
package whack_pkg;

    localparam int               LFSR_W     = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam int               TICK_CNT_W = 16;

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_GAP = 2'd1,
        S_UP  = 2'd2
    } state_t;

    // Galois step for x^16+x^14+x^13+x^11+1, shifting towards bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {1'b0, s[LFSR_W-1:1]} ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Purpose: free-running 16-bit Galois LFSR; a zero seed is replaced by 1.
// Latency: state advances once per clock outside reset.
// Backpressure: none, never stalls.
module mole_lfsr
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [LFSR_W-1:0] o_state
);

    localparam logic [LFSR_W-1:0] C_SEED = (SEED == '0) ? 16'h0001 : SEED;

    logic [LFSR_W-1:0] r_state;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= C_SEED;
        else          r_state <= lfsr_next(r_state);
    end

    assign o_state = r_state;

endmodule

// File: rtl/mole_scheduler.sv
// Purpose: raises one pseudo-random mole at a time, reports hit/miss; MOLE_WRONG_PENALTY_EN makes wrong-hole presses a miss.
// Latency: all outputs registered; a hit edge sampled at edge k shows hit_pulse after edge k.
// Backpressure: none; tick and button inputs are sampled every cycle and never stalled.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int                N_HOLES   = 4,
    parameter int                UP_TICKS  = 500,
    parameter int                GAP_TICKS = 200,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    localparam int               IDX_W     = $clog2(N_HOLES)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               game_active,
    input  logic               tick,
    input  logic [N_HOLES-1:0] hit_btn,
    output logic [N_HOLES-1:0] mole_led,
    output logic [IDX_W-1:0]   mole_idx,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam logic [TICK_CNT_W-1:0] C_UP  = TICK_CNT_W'(UP_TICKS);
    localparam logic [TICK_CNT_W-1:0] C_GAP = TICK_CNT_W'(GAP_TICKS);
    localparam logic [TICK_CNT_W-1:0] C_ONE = TICK_CNT_W'(1);
    localparam logic [N_HOLES-1:0]    C_LED0 = N_HOLES'(1);

    state_t                r_state, w_nxt_state;
    logic [TICK_CNT_W-1:0] r_cnt, w_nxt_cnt;
    logic [N_HOLES-1:0]    r_btn_prev;
    logic [N_HOLES-1:0]    r_led, w_nxt_led;
    logic [IDX_W-1:0]      r_idx, w_nxt_idx;
    logic                  r_hit, w_nxt_hit;
    logic                  r_miss, w_nxt_miss;
    logic                  r_first, w_nxt_first;

    logic [LFSR_W-1:0]     w_lfsr;
    logic [N_HOLES-1:0]    w_edge;
    logic [IDX_W-1:0]      w_pick, w_pick_adj;
    logic                  w_unused_lfsr;

    mole_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .o_state (w_lfsr)
    );

    assign w_edge        = hit_btn & ~r_btn_prev;
    assign w_pick        = w_lfsr[IDX_W-1:0];
    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:IDX_W];
    // Never repeat the previous hole, except for the first mole of a round.
    assign w_pick_adj    = (!r_first && (w_pick == r_idx)) ? w_pick + IDX_W'(1) : w_pick;

`ifdef MOLE_WRONG_PENALTY_EN
    logic w_wrong;
    assign w_wrong = |(w_edge & ~r_led);
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_led   = r_led;
        w_nxt_idx   = r_idx;
        w_nxt_hit   = 1'b0;
        w_nxt_miss  = 1'b0;
        w_nxt_first = r_first;
        if (!game_active) begin
            w_nxt_state = S_OFF;
            w_nxt_led   = '0;
            w_nxt_cnt   = '0;
        end else begin
            case (r_state)
                S_OFF: begin
                    w_nxt_state = S_GAP;
                    w_nxt_cnt   = C_GAP;
                    w_nxt_first = 1'b1;
                end
                S_GAP: begin
                    if (tick) begin
                        if (r_cnt == C_ONE) begin
                            w_nxt_state = S_UP;
                            w_nxt_idx   = w_pick_adj;
                            w_nxt_led   = C_LED0 << w_pick_adj;
                            w_nxt_cnt   = C_UP;
                            w_nxt_first = 1'b0;
                        end else begin
                            w_nxt_cnt = r_cnt - C_ONE;
                        end
                    end
                end
                S_UP: begin
                    if (w_edge[r_idx]) begin
                        w_nxt_hit   = 1'b1;
                        w_nxt_led   = '0;
                        w_nxt_cnt   = C_GAP;
                        w_nxt_state = S_GAP;
                    end
`ifdef MOLE_WRONG_PENALTY_EN
                    else if (w_wrong) begin
                        w_nxt_miss  = 1'b1;
                        w_nxt_led   = '0;
                        w_nxt_cnt   = C_GAP;
                        w_nxt_state = S_GAP;
                    end
`endif
                    else if (tick) begin
                        if (r_cnt == C_ONE) begin
                            w_nxt_miss  = 1'b1;
                            w_nxt_led   = '0;
                            w_nxt_cnt   = C_GAP;
                            w_nxt_state = S_GAP;
                        end else begin
                            w_nxt_cnt = r_cnt - C_ONE;
                        end
                    end
                end
                default: w_nxt_state = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_OFF;
            r_cnt      <= '0;
            r_btn_prev <= '0;
            r_led      <= '0;
            r_idx      <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_first    <= 1'b1;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_btn_prev <= hit_btn;
            r_led      <= w_nxt_led;
            r_idx      <= w_nxt_idx;
            r_hit      <= w_nxt_hit;
            r_miss     <= w_nxt_miss;
            r_first    <= w_nxt_first;
        end
    end

    assign mole_led   = r_led;
    assign mole_idx   = r_idx;
    assign hit_pulse  = r_hit;
    assign miss_pulse = r_miss;

endmodule

// File: tb/tb_mole_scheduler.sv
// Bench for mole_scheduler: cycle reference model feeding a scoreboard, plus directed scenario checks.
module tb_mole_scheduler;

    localparam int NH  = 4;
    localparam int UPT = 4;
    localparam int GPT = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       game_active;
    logic       tick;
    logic [3:0] hit_btn;
    logic [3:0] mole_led;
    logic [1:0] mole_idx;
    logic       hit_pulse;
    logic       miss_pulse;

    always #5 clk = ~clk;

    mole_scheduler #(
        .N_HOLES   (NH),
        .UP_TICKS  (UPT),
        .GAP_TICKS (GPT),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .game_active (game_active),
        .tick        (tick),
        .hit_btn     (hit_btn),
        .mole_led    (mole_led),
        .mole_idx    (mole_idx),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse)
    );

    typedef struct packed {
        logic [3:0] led;
        logic [1:0] idx;
        logic       hit;
        logic       miss;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model state: 0 = off, 1 = gap, 2 = up.
    int          m_st, m_cnt;
    logic [3:0]  m_prev, m_led;
    logic [1:0]  m_idx;
    logic        m_hit, m_miss, m_first;
    logic [15:0] m_lfsr;

    task automatic model_step();
        logic [3:0]  e;
        logic [1:0]  p;
        logic [15:0] nl;
        if (!reset_n) begin
            m_st = 0; m_cnt = 0; m_prev = 0; m_led = 0; m_idx = 0;
            m_hit = 0; m_miss = 0; m_first = 1; m_lfsr = 16'hACE1;
        end else begin
            e = hit_btn & ~m_prev;
            m_hit = 0;
            m_miss = 0;
            nl = m_lfsr >> 1;
            if (m_lfsr[0]) nl = nl ^ 16'hB400;
            if (!game_active) begin
                m_st = 0; m_led = 0; m_cnt = 0;
            end else if (m_st == 0) begin
                m_st = 1; m_cnt = GPT; m_first = 1;
            end else if (m_st == 1) begin
                if (tick && m_cnt == 1) begin
                    p = m_lfsr[1:0];
                    if (!m_first && p == m_idx) p = p + 2'd1;
                    m_idx = p; m_led = 4'b0001 << p; m_first = 0;
                    m_cnt = UPT; m_st = 2;
                end else if (tick) m_cnt--;
            end else begin
                if (e[m_idx]) begin
                    m_hit = 1; m_led = 0; m_cnt = GPT; m_st = 1;
                end
`ifdef MOLE_WRONG_PENALTY_EN
                else if ((e & ~m_led) != 0) begin
                    m_miss = 1; m_led = 0; m_cnt = GPT; m_st = 1;
                end
`endif
                else if (tick && m_cnt == 1) begin
                    m_miss = 1; m_led = 0; m_cnt = GPT; m_st = 1;
                end else if (tick) m_cnt--;
            end
            m_prev = hit_btn;
            m_lfsr = nl;
        end
        sb_q.push_back('{led: m_led, idx: m_idx, hit: m_hit, miss: m_miss});
    endtask

    task automatic step();
        exp_t ex;
        model_step();
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            ex = sb_q.pop_front();
            chk("mole_led", mole_led, ex.led);
            chk("mole_idx", mole_idx, ex.idx);
            chk("hit_pulse", hit_pulse, ex.hit);
            chk("miss_pulse", miss_pulse, ex.miss);
        end
    endtask

    task automatic wait_mole(input string tag, output int n);
        n = 0;
        while (mole_led == 0 && n < 40) begin
            step();
            n++;
        end
        if (mole_led == 0) chk({tag, "_mole_timeout"}, 0, 1);
    endtask

    task automatic wait_clear(input string tag, output int n);
        n = 0;
        while (mole_led != 0 && n < 40) begin
            step();
            n++;
        end
        if (mole_led != 0) chk({tag, "_clear_timeout"}, 0, 1);
    endtask

    initial begin
        int         n;
        logic [1:0] prev;
        logic [1:0] wrong;

        reset_n = 1'b0; game_active = 1'b1; tick = 1'b1; hit_btn = 4'h0;
        repeat (3) step();
        chk("reset_led", mole_led, 0);
        chk("reset_lfsr", dut.u_lfsr.o_state, 16'hACE1);

        // First mole: rise two ticks after gap entry, up four cycles, then miss.
        reset_n = 1'b1;
        wait_mole("first", n);
        chk("first_rise_cycles", n, 3);
        chk("first_led_onehot", $countones(mole_led), 1);
        wait_clear("first", n);
        chk("first_up_cycles", n, 4);
        chk("first_timeout_miss", miss_pulse, 1);

        // Hit on the second up cycle.
        wait_mole("hit", n);
        chk("gap_cycles", n, 2);
        prev = mole_idx;
        step();
        hit_btn = 4'b0001 << prev;
        step();
        chk("hit_pulse_hit", hit_pulse, 1);
        chk("hit_led_clear", mole_led, 0);
        hit_btn = 4'h0;
        wait_mole("after_hit", n);
        chk("after_hit_gap", n, 2);
        chk("idx_not_repeated", (mole_idx != prev), 1);
        wait_clear("after_hit", n);

        // Button held across the rise does not count; release and press does.
        hit_btn = 4'hF;
        wait_mole("held", n);
        step();
        chk("held_no_hit", hit_pulse, 0);
        hit_btn = 4'h0;
        step();
        hit_btn = 4'b0001 << mole_idx;
        step();
        chk("repress_hit", hit_pulse, 1);
        hit_btn = 4'h0;

        // Correct press on the timeout cycle: hit wins.
        wait_mole("race", n);
        repeat (3) step();
        hit_btn = 4'b0001 << mole_idx;
        step();
        chk("race_hit", hit_pulse, 1);
        chk("race_no_miss", miss_pulse, 0);
        hit_btn = 4'h0;

        // Wrong-hole press.
        wait_mole("wrong", n);
        wrong = mole_idx + 2'd1;
        hit_btn = 4'b0001 << wrong;
        step();
`ifdef MOLE_WRONG_PENALTY_EN
        chk("wrong_penalty_miss", miss_pulse, 1);
        chk("wrong_penalty_clear", mole_led, 0);
`else
        chk("wrong_ignored", miss_pulse | hit_pulse, 0);
        chk("wrong_stays_up", (mole_led != 0), 1);
        wait_clear("wrong", n);
        chk("wrong_up_remaining", n, 3);
        chk("wrong_then_timeout", miss_pulse, 1);
`endif
        hit_btn = 4'h0;

        // Drop game_active together with a correct press.
        wait_mole("drop", n);
        step();
        game_active = 1'b0;
        hit_btn = 4'b0001 << mole_idx;
        step();
        chk("drop_no_hit", hit_pulse, 0);
        chk("drop_no_miss", miss_pulse, 0);
        chk("drop_led_clear", mole_led, 0);
        hit_btn = 4'h0;
        step();
        game_active = 1'b1;
        wait_mole("restart", n);
        chk("restart_full_gap", n, 3);

        // Reset mid-round.
        step();
        reset_n = 1'b0;
        step();
        chk("midreset_led", mole_led, 0);
        chk("midreset_idx", mole_idx, 0);
        chk("midreset_lfsr", dut.u_lfsr.o_state, 16'hACE1);
        reset_n = 1'b1;

        // Random play against the model.
        for (int i = 0; i < 400; i++) begin
            hit_btn = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            game_active = ($urandom_range(0, 79) != 0);
            tick = ($urandom_range(0, 7) != 0);
            step();
            chk("pulse_exclusive", hit_pulse & miss_pulse, 0);
        end

        chk("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
# mole_scheduler

Sequences the moles during a round of whack-a-mole. While the game FSM holds `game_active` high, the block uses a pseudo-random pick to raise one mole at a time on one of `N_HOLES` holes. Each mole stays up for a fixed number of timebase ticks, then the block reports a hit or a miss to the score counter. It sits between the game FSM, the debounced hole buttons, the LED driver and the scorer.

## Interface
- `N_HOLES`, 4: number of holes. Must be a power of 2 in the range 2..16. `IDX_W = $clog2(N_HOLES)`.
- `UP_TICKS`, 500: ticks a mole stays up. Must be ≥1; counter is 16 bits.
- `GAP_TICKS`, 200: ticks between moles. Must be ≥1; counter is 16 bits.
- `LFSR_SEED`, 16'hACE1: LFSR reset value. A zero value is replaced by 16'h0001.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `game_active`  in  1  level from the game FSM; 1 = round in progress.
- `tick`  in  1  one-cycle timebase enable (e.g. 1 ms strobe).
- `hit_btn`  in  N_HOLES  debounced button levels, bit i = hole i.
- `mole_led`  out  N_HOLES  one-hot while a mole is up, else 0.
- `mole_idx`  out  IDX_W  index of the current or most recent mole.
- `hit_pulse`  out  1  one-cycle pulse when the correct hole is hit.
- `miss_pulse`  out  1  one-cycle pulse when a mole times out (or on a wrong hit, see Configuration).

## Operation
- States:
  - S_OFF: idle.
  - S_GAP: waiting between moles.
  - S_UP: a mole is showing.
- Reset, synchronous on `reset_n`=0:
  - State goes to S_OFF.
  - `mole_led`=0, `mole_idx`=0, `hit_pulse`=0, `miss_pulse`=0.
  - Counter = 0, button history = 0, LFSR = seed.
- S_OFF → S_GAP when `game_active`=1. On entry the counter loads `GAP_TICKS`.
- S_GAP: the counter decrements on each `tick`. When `tick`=1 and the counter is 1, the block picks a hole and goes to S_UP:
  - The pick is `lfsr[IDX_W-1:0]`.
  - If the pick equals the previous `mole_idx`, the block uses `(pick+1) mod N_HOLES` instead. The first mole of a round is exempt from this rule.
  - `mole_idx` is updated, `mole_led` = 1<<`mole_idx`, and the counter loads `UP_TICKS`.
- S_UP:
  - A button edge is a rising edge, i.e. `hit_btn & ~btn_prev`. `btn_prev` is registered every cycle in all states.
  - An edge on bit `mole_idx` gives `hit_pulse`, clears `mole_led`, loads `GAP_TICKS` and goes to S_GAP.
  - Otherwise, if `tick`=1 and the counter is 1, the block gives `miss_pulse`, clears `mole_led`, loads `GAP_TICKS` and goes to S_GAP.
  - An edge on any other bit is ignored unless the penalty feature is compiled in.
  - A button already held when the mole rises does not count; the player must release and press again.
- `game_active`=0 in any state: next state is S_OFF, `mole_led` is cleared, no pulse is issued, and the counter is cleared. This overrides a hit or timeout in the same cycle.
- The LFSR is 16-bit Galois with polynomial x^16+x^14+x^13+x^11+1. It advances every cycle outside reset, so the pick depends on player timing.

## Timing
- All outputs are registered. Each is a pure function of values registered at the previous edge.
- A mole is up for exactly `UP_TICKS` tick strobes. The gap is exactly `GAP_TICKS` strobes.
- Hit latency: if the button edge is sampled at edge k, then after edge k `hit_pulse`=1 for one cycle and `mole_led`=0.
- Hit and timeout in the same cycle: hit wins. `miss_pulse` is not issued.
- `hit_pulse` and `miss_pulse` are never high together, and each is high for exactly one cycle.
- If `game_active` rises again after S_OFF, the new round starts with a full `GAP_TICKS` gap.

## Configuration
- `MOLE_WRONG_PENALTY_EN` defined: in S_UP, a rising edge on any non-mole bit with no correct edge in the same cycle ends the mole like a timeout (`miss_pulse`, then S_GAP). A correct edge in the same cycle wins and gives a hit.
- Not defined: wrong-hole edges are ignored and the mole stays up until it is hit or times out.

## Structure
- Package `whack_pkg`:
  - state enum (S_OFF/S_GAP/S_UP, 2 bits)
  - `LFSR_W`=16 and the tap mask 16'hB400
  - counter width `TICK_CNT_W`=16
- Sub-module `mole_lfsr`: the free-running Galois LFSR with seed parameter and zero-seed guard. Output is the 16-bit state.
- The top level holds the FSM, the tick counter, button edge detection and output registers.

## Test plan
Bench settings for all scenarios: `N_HOLES`=4, `UP_TICKS`=4, `GAP_TICKS`=2, `tick` high every cycle.
- Reset, then `game_active`=1 held → all outputs 0 during reset. The first `mole_led` becomes one-hot 2 ticks after S_GAP entry and stays up exactly 4 cycles, then `miss_pulse`=1 for 1 cycle.
- Mole at idx 2; press `hit_btn`=4'b0100 on the 2nd up cycle → `hit_pulse`=1 for 1 cycle, `mole_led`=0 on the same cycle, next mole 2 cycles later with idx ≠2.
- Hold `hit_btn[idx]`=1 from before the mole rises → no hit. Release then press → hit.
- Correct edge on the same cycle as the timeout → `hit_pulse`=1, `miss_pulse`=0.
- Wrong-hole press (bit ≠ `mole_idx`) → no pulse and the mole stays up 4 cycles. With `MOLE_WRONG_PENALTY_EN` → `miss_pulse` on the next cycle and the mole cleared.
- Drop `game_active` mid S_UP, together with a correct press → no pulse, `mole_led`=0 next cycle. Then set `reset_n`=0 mid-round → all outputs 0 and the LFSR reseeds to 16'hACE1.
